// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID pipeline register,
// halt detection and illegal-fetch fault handling.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 64,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        Stall,
  input  logic        Branch_taken,
  input  logic [31:0] Branch_target,
  input  logic        Jump,
  input  logic [25:0] Jump_index,
  input  logic [31:0] Instruction,
  output logic [31:0] Read_address,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PC_plus4,
  output logic        IF_ID_Valid,
  output logic        Halted,
  output logic        Fault
);

  typedef enum logic [1:0] {BOOT, RUN, HALT, FAULT} state_t;

  localparam logic [32:0] PC_LIMIT = 33'(MEM_WORDS) * 33'd4;

  state_t      state, state_next;
  logic [31:0] pc, pc_plus4, sel_pc;
  logic        redirect, illegal, halt_hit;

  assign Read_address = pc;
  assign pc_plus4     = pc + 32'd4;
  assign redirect     = Jump | Branch_taken;

  always_comb begin
    sel_pc = pc_plus4;
    if (Jump)              sel_pc = {pc_plus4[31:28], Jump_index, 2'b00};
    else if (Branch_taken) sel_pc = Branch_target;
    else if (Stall)        sel_pc = pc;
  end

  // Fault is evaluated on the selected PC and takes priority over halt.
  assign illegal  = (sel_pc[1:0] != 2'b00) || ({1'b0, sel_pc} >= PC_LIMIT);
  assign halt_hit = !redirect && !Stall && (Instruction == HALT_WORD);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= BOOT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      BOOT: state_next = RUN;
      RUN: begin
        if (illegal)       state_next = FAULT;
        else if (halt_hit) state_next = HALT;
      end
      default: state_next = state;
    endcase
  end

  always_comb begin
    Halted = (state == HALT);
    Fault  = (state == FAULT);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pc                <= RESET_PC;
      IF_ID_Instruction <= '0;
      IF_ID_PC_plus4    <= '0;
      IF_ID_Valid       <= 1'b0;
    end else if (state == RUN) begin
      if (illegal || halt_hit) begin
        IF_ID_Instruction <= '0;
        IF_ID_PC_plus4    <= '0;
        IF_ID_Valid       <= 1'b0;
      end else begin
        pc <= sel_pc;
        if (redirect) begin
          IF_ID_Instruction <= '0;
          IF_ID_PC_plus4    <= '0;
          IF_ID_Valid       <= 1'b0;
        end else if (!Stall) begin
          IF_ID_Instruction <= Instruction;
          IF_ID_PC_plus4    <= pc_plus4;
          IF_ID_Valid       <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus randomized run
// against a behavioural fetch model.
module tb_pc_fetch_unit;

  localparam int unsigned MEM_WORDS = 64;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        Stall, Branch_taken, Jump;
  logic [31:0] Branch_target, Instruction;
  logic [25:0] Jump_index;
  logic [31:0] Read_address, IF_ID_Instruction, IF_ID_PC_plus4;
  logic        IF_ID_Valid, Halted, Fault;

  int checks = 0;
  int failures = 0;

  // behavioural model state
  logic [31:0] m_pc, m_ins, m_p4;
  logic        m_v, m_boot, m_halt, m_fault;

  pc_fetch_unit #(.RESET_PC(32'h0), .MEM_WORDS(MEM_WORDS), .HALT_WORD(HALT_WORD)) dut (
    .CLK(CLK), .RESET(RESET), .Stall(Stall), .Branch_taken(Branch_taken),
    .Branch_target(Branch_target), .Jump(Jump), .Jump_index(Jump_index),
    .Instruction(Instruction), .Read_address(Read_address),
    .IF_ID_Instruction(IF_ID_Instruction), .IF_ID_PC_plus4(IF_ID_PC_plus4),
    .IF_ID_Valid(IF_ID_Valid), .Halted(Halted), .Fault(Fault)
  );

  always #5 CLK = ~CLK;

  task automatic model_reset();
    m_pc = 0; m_ins = 0; m_p4 = 0; m_v = 0;
    m_boot = 1; m_halt = 0; m_fault = 0;
  endtask

  task automatic model_step();
    longint unsigned np;
    logic [31:0] p4;
    if (m_boot) m_boot = 0;
    else if (!m_halt && !m_fault) begin
      p4 = m_pc + 32'd4;
      if (Jump)              np = {p4[31:28], Jump_index, 2'b00};
      else if (Branch_taken) np = Branch_target;
      else if (Stall)        np = m_pc;
      else                   np = longint'(m_pc) + 4;
      if (np >= 64'h1_0000_0000) np = np - 64'h1_0000_0000;
      if ((np % 4) != 0 || np >= MEM_WORDS * 4) begin
        m_fault = 1; m_ins = 0; m_p4 = 0; m_v = 0;
      end else if (!Jump && !Branch_taken && !Stall && Instruction == HALT_WORD) begin
        m_halt = 1; m_ins = 0; m_p4 = 0; m_v = 0;
      end else begin
        m_pc = np[31:0];
        if (Jump || Branch_taken) begin m_ins = 0; m_p4 = 0; m_v = 0; end
        else if (!Stall) begin m_ins = Instruction; m_p4 = p4; m_v = 1; end
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    Stall = 0; Branch_taken = 0; Jump = 0;
    Branch_target = 0; Jump_index = 0; Instruction = 32'h0000_0013;
  endtask

  task automatic pulse_reset();
    RESET = 0; model_reset();
    #2; RESET = 1;
  endtask

  task automatic test_reset();
    clear_inputs(); RESET = 0; model_reset();
    #3;
    checks++; if (Read_address !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", Read_address); end
    checks++; if (IF_ID_Valid !== 1'b0 || IF_ID_Instruction !== 32'h0 || IF_ID_PC_plus4 !== 32'h0) begin
      failures++; $display("FAIL reset_ifid got=%b/%h/%h exp=0/0/0", IF_ID_Valid, IF_ID_Instruction, IF_ID_PC_plus4); end
    checks++; if (Halted !== 1'b0 || Fault !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", Halted, Fault); end
    RESET = 1; Instruction = 32'h2001_0005;
    tick();
    checks++; if (Read_address !== 32'h0 || IF_ID_Valid !== 1'b0) begin
      failures++; $display("FAIL boot_bubble got pc=%h v=%b exp pc=0 v=0", Read_address, IF_ID_Valid); end
    tick();
    checks++; if (Read_address !== 32'h4 || IF_ID_Valid !== 1'b1 || IF_ID_Instruction !== 32'h2001_0005 || IF_ID_PC_plus4 !== 32'h4) begin
      failures++; $display("FAIL first_fetch got pc=%h v=%b i=%h p4=%h exp 4/1/20010005/4",
                           Read_address, IF_ID_Valid, IF_ID_Instruction, IF_ID_PC_plus4); end
  endtask

  task automatic test_stall();
    Instruction = 32'h1111_0004;
    tick();  // PC 4 -> 8
    Instruction = 32'h2222_0008; Stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (Read_address !== 32'h8 || IF_ID_Instruction !== 32'h1111_0004 || IF_ID_PC_plus4 !== 32'h8 || IF_ID_Valid !== 1'b1) begin
        failures++; $display("FAIL stall_hold[%0d] got pc=%h i=%h p4=%h v=%b exp 8/11110004/8/1",
                             i, Read_address, IF_ID_Instruction, IF_ID_PC_plus4, IF_ID_Valid); end
    end
    Stall = 0;
    tick();
    checks++; if (Read_address !== 32'hC || IF_ID_Instruction !== 32'h2222_0008 || IF_ID_PC_plus4 !== 32'hC) begin
      failures++; $display("FAIL stall_release got pc=%h i=%h p4=%h exp c/22220008/c", Read_address, IF_ID_Instruction, IF_ID_PC_plus4); end
  endtask

  task automatic test_redirect();
    tick();  // PC 12 -> 16
    checks++; if (Read_address !== 32'h10) begin failures++; $display("FAIL pre_branch_pc got=%h exp=10", Read_address); end
    Branch_taken = 1; Stall = 1; Branch_target = 32'd40;
    tick();
    checks++; if (Read_address !== 32'd40 || IF_ID_Valid !== 1'b0 || IF_ID_Instruction !== 32'h0 || IF_ID_PC_plus4 !== 32'h0) begin
      failures++; $display("FAIL branch_over_stall got pc=%h v=%b i=%h p4=%h exp 28/0/0/0",
                           Read_address, IF_ID_Valid, IF_ID_Instruction, IF_ID_PC_plus4); end
    Jump = 1; Jump_index = 26'h3;
    tick();
    checks++; if (Read_address !== 32'd12 || IF_ID_Valid !== 1'b0) begin
      failures++; $display("FAIL jump_wins got pc=%h v=%b exp c/0", Read_address, IF_ID_Valid); end
    clear_inputs();
  endtask

  task automatic test_halt();
    clear_inputs(); pulse_reset();
    tick();  // BOOT
    for (int i = 0; i < 5; i++) tick();
    checks++; if (Read_address !== 32'd20) begin failures++; $display("FAIL pre_halt_pc got=%h exp=14", Read_address); end
    Instruction = HALT_WORD;
    tick();
    checks++; if (Halted !== 1'b1 || Read_address !== 32'd20 || IF_ID_Valid !== 1'b0 || IF_ID_Instruction !== 32'h0) begin
      failures++; $display("FAIL halt_enter got h=%b pc=%h v=%b i=%h exp 1/14/0/0", Halted, Read_address, IF_ID_Valid, IF_ID_Instruction); end
    Branch_taken = 1; Branch_target = 32'd40; Instruction = 32'h0000_0013;
    tick(); tick();
    checks++; if (Halted !== 1'b1 || Read_address !== 32'd20) begin
      failures++; $display("FAIL halt_absorb got h=%b pc=%h exp 1/14", Halted, Read_address); end
    #2; RESET = 0; model_reset(); #1;
    checks++; if (Halted !== 1'b0 || Read_address !== 32'h0) begin
      failures++; $display("FAIL halt_reset got h=%b pc=%h exp 0/0", Halted, Read_address); end
    RESET = 1; clear_inputs();
  endtask

  task automatic test_fault();
    clear_inputs(); pulse_reset();
    tick(); tick();  // PC = 4
    Branch_taken = 1; Branch_target = 32'h0000_0102;
    tick();
    checks++; if (Fault !== 1'b1 || Read_address !== 32'h4 || IF_ID_Valid !== 1'b0) begin
      failures++; $display("FAIL fault_misaligned got f=%b pc=%h v=%b exp 1/4/0", Fault, Read_address, IF_ID_Valid); end
    clear_inputs(); pulse_reset();
    tick();
    Branch_taken = 1; Branch_target = 32'd256;
    tick();
    checks++; if (Fault !== 1'b1 || Read_address !== 32'h0) begin
      failures++; $display("FAIL fault_range got f=%b pc=%h exp 1/0", Fault, Read_address); end
    clear_inputs(); pulse_reset();
    tick();
    Branch_taken = 1; Branch_target = 32'd252;
    tick();
    checks++; if (Fault !== 1'b0 || Read_address !== 32'd252) begin
      failures++; $display("FAIL last_word got f=%b pc=%h exp 0/fc", Fault, Read_address); end
    Branch_taken = 0; Instruction = HALT_WORD;  // fault outranks halt
    tick();
    checks++; if (Fault !== 1'b1 || Halted !== 1'b0 || Read_address !== 32'd252) begin
      failures++; $display("FAIL fall_off_end got f=%b h=%b pc=%h exp 1/0/fc", Fault, Halted, Read_address); end
    clear_inputs();
  endtask

  task automatic test_async_reset();
    clear_inputs(); pulse_reset();
    for (int i = 0; i < 4; i++) tick();
    Stall = 1;
    tick();
    #3; RESET = 0; model_reset(); #1;
    checks++; if (Read_address !== 32'h0 || IF_ID_Valid !== 1'b0 || IF_ID_Instruction !== 32'h0 || IF_ID_PC_plus4 !== 32'h0 || Halted !== 1'b0 || Fault !== 1'b0) begin
      failures++; $display("FAIL async_reset got pc=%h v=%b i=%h p4=%h h=%b f=%b exp all 0",
                           Read_address, IF_ID_Valid, IF_ID_Instruction, IF_ID_PC_plus4, Halted, Fault); end
    RESET = 1; clear_inputs();
  endtask

  task automatic test_random();
    int stuck = 0;
    clear_inputs(); pulse_reset();
    for (int n = 0; n < 600; n++) begin
      Stall        = ($urandom_range(0, 3) == 0);
      Jump         = ($urandom_range(0, 9) == 0);
      Branch_taken = ($urandom_range(0, 7) == 0);
      Jump_index   = 26'($urandom_range(0, 66));
      Branch_target = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 300))
                                                  : 32'($urandom_range(0, 63) * 4);
      Instruction  = ($urandom_range(0, 11) == 0) ? HALT_WORD : $urandom;
      tick();
      checks++; if (Read_address !== m_pc || IF_ID_Valid !== m_v || IF_ID_Instruction !== m_ins ||
                    Halted !== m_halt || Fault !== m_fault || (!m_halt && !m_fault && IF_ID_PC_plus4 !== m_p4)) begin
        failures++; $display("FAIL random[%0d] got pc=%h v=%b i=%h p4=%h h=%b f=%b exp pc=%h v=%b i=%h p4=%h h=%b f=%b",
                             n, Read_address, IF_ID_Valid, IF_ID_Instruction, IF_ID_PC_plus4, Halted, Fault,
                             m_pc, m_v, m_ins, m_p4, m_halt, m_fault); end
      if (m_halt || m_fault) stuck++;
      if (stuck > 3) begin stuck = 0; pulse_reset(); end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_halt();
    test_fault();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
